// File: rtl/seq_gate_detector.sv
// Serial pattern detector with a programmable pattern (1..PAT_MAX bits) that,
// on a match, forwards the next win_len strobed bits and counts detections.
module seq_gate_detector #(
  parameter int                 PAT_MAX = 8,
  parameter int                 CNT_W   = 11,
  parameter logic [PAT_MAX-1:0] DEF_PAT = 8'b00011110,
  parameter int                 DEF_LEN = 6,
  parameter int                 DEF_WIN = 1024,
  localparam int                LW      = $clog2(PAT_MAX+1)
) (
  input  logic               FPGAclk,
  input  logic               rst,
  input  logic               bit_valid,
  input  logic               ser_in,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] pat_cfg,
  input  logic [LW-1:0]      pat_len,
  input  logic [CNT_W-1:0]   win_len,
  input  logic               retrig_en,
  output logic               ser_out,
  output logic               ser_out_valid,
  output logic               gate_active,
  output logic               det_pulse,
  output logic [15:0]        det_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, GATE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PAT_MAX-1:0] hist_q, pat_q;
  logic [LW-1:0]      fill_q, len_q;
  logic [CNT_W-1:0]   rem_q, win_q;
  logic               retrig_q;
  logic               ser_out_q, ser_out_valid_q, det_pulse_q;
  logic [15:0]        det_count_q;

  logic [PAT_MAX-1:0] hist_sh, mask;
  logic [LW-1:0]      fill_inc;
  logic               bit_ok, match, hunt_hit, gate_hit, any_hit, fwd, last, cfg_bad, shift_en;

  // A strobe coinciding with cfg_load is dropped entirely.
  assign bit_ok   = bit_valid && !cfg_load;
  assign hist_sh  = {hist_q[PAT_MAX-2:0], ser_in};
  assign fill_inc = (fill_q == LW'(PAT_MAX)) ? fill_q : fill_q + 1'b1;
  assign cfg_bad  = (pat_len == '0) || (int'(pat_len) > PAT_MAX);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = (i < int'(len_q));
  end

  assign match    = bit_ok && (len_q != '0) && (fill_inc >= len_q) &&
                    ((hist_sh & mask) == (pat_q & mask));
  assign hunt_hit = (state_q == HUNT) && match;
  assign gate_hit = (state_q == GATE) && retrig_q && match;
  assign any_hit  = hunt_hit || gate_hit;
  assign fwd      = (state_q == GATE) && bit_ok;
  assign last     = fwd && !gate_hit && (rem_q == CNT_W'(1));
  assign shift_en = bit_ok && ((state_q == HUNT) || ((state_q == GATE) && retrig_q));

  // State register
  always_ff @(posedge FPGAclk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = cfg_bad ? IDLE : HUNT;
    end else begin
      case (state_q)
        HUNT:    if (hunt_hit && (win_q != '0)) state_d = GATE;
        GATE:    if (last) state_d = HUNT;
        IDLE:    state_d = IDLE;
        default: state_d = HUNT;
      endcase
    end
  end

  // Outputs
  always_comb begin
    gate_active   = (state_q == GATE);
    cfg_err       = (state_q == IDLE);
    ser_out       = ser_out_q;
    ser_out_valid = ser_out_valid_q;
    det_pulse     = det_pulse_q;
    det_count     = det_count_q;
  end

  // Held configuration
  always_ff @(posedge FPGAclk or posedge rst) begin
    if (rst) begin
      pat_q    <= DEF_PAT;
      len_q    <= LW'(DEF_LEN);
      win_q    <= CNT_W'(DEF_WIN);
      retrig_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q    <= pat_cfg;
      len_q    <= pat_len;
      win_q    <= win_len;
      retrig_q <= retrig_en;
    end
  end

  // History and window counter; any accepted match restarts the history so
  // detections never overlap.
  always_ff @(posedge FPGAclk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      rem_q  <= '0;
    end else begin
      if (cfg_load || any_hit) begin
        hist_q <= '0;
        fill_q <= '0;
      end else if (shift_en) begin
        hist_q <= hist_sh;
        fill_q <= fill_inc;
      end
      if (cfg_load)                             rem_q <= '0;
      else if (gate_hit || (hunt_hit && win_q != '0)) rem_q <= win_q;
      else if (fwd)                             rem_q <= rem_q - 1'b1;
    end
  end

  // Forwarding and detection outputs
  always_ff @(posedge FPGAclk or posedge rst) begin
    if (rst) begin
      ser_out_q       <= 1'b0;
      ser_out_valid_q <= 1'b0;
      det_pulse_q     <= 1'b0;
      det_count_q     <= '0;
    end else begin
      ser_out_valid_q <= fwd;
      det_pulse_q     <= any_hit;
      if (any_hit && (det_count_q != 16'hFFFF)) det_count_q <= det_count_q + 1'b1;
      // The final bit of a window is still shown once; ser_out clears the cycle after.
      if (fwd)                  ser_out_q <= ser_in;
      else if (state_d != GATE) ser_out_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_gate_detector.sv
// Directed bench for seq_gate_detector with hand-computed expectations.
module tb_seq_gate_detector;
  logic        FPGAclk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_valid = 1'b0, ser_in = 1'b0, cfg_load = 1'b0, retrig_en = 1'b0;
  logic [7:0]  pat_cfg = '0;
  logic [3:0]  pat_len = '0;
  logic [10:0] win_len = '0;
  logic        ser_out, ser_out_valid, gate_active, det_pulse, cfg_err;
  logic [15:0] det_count;

  int nvec = 0, nerr = 0;

  seq_gate_detector dut (
    .FPGAclk(FPGAclk), .rst(rst), .bit_valid(bit_valid), .ser_in(ser_in),
    .cfg_load(cfg_load), .pat_cfg(pat_cfg), .pat_len(pat_len), .win_len(win_len),
    .retrig_en(retrig_en), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .gate_active(gate_active), .det_pulse(det_pulse), .det_count(det_count),
    .cfg_err(cfg_err)
  );

  always #5 FPGAclk = ~FPGAclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge FPGAclk); #1;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1; ser_in = b;
    @(posedge FPGAclk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic [10:0] w, input logic r);
    pat_cfg = p; pat_len = l; win_len = w; retrig_en = r; cfg_load = 1'b1;
    @(posedge FPGAclk); #1;
    cfg_load = 1'b0;
  endtask

  initial begin
    logic b;
    int pulses, good;
    logic [6:0] seq;

    // Reset state
    rst = 1'b1; #2;
    chk("rst_ser_out", ser_out, 0);
    chk("rst_valid", ser_out_valid, 0);
    chk("rst_gate", gate_active, 0);
    chk("rst_det", det_pulse, 0);
    chk("rst_count", det_count, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    @(posedge FPGAclk); #1;

    // Default config: 011110 then a 1024-bit window
    send(0); send(1); send(1); send(1); send(1);
    chk("def_no_early_det", det_pulse, 0);
    send(0);
    chk("def_det", det_pulse, 1);
    chk("def_gate_on", gate_active, 1);
    chk("def_count1", det_count, 1);
    pulses = 0; good = 0;
    for (int i = 0; i < 1024; i++) begin
      b = 1'($urandom);
      send(b);
      if (ser_out_valid) pulses++;
      if (ser_out_valid && ser_out === b) good++;
    end
    chk("def_pulses", pulses, 1024);
    chk("def_echo", good, 1024);
    chk("def_last_valid", ser_out_valid, 1);
    chk("def_gate_off", gate_active, 0);
    for (int i = 0; i < 6; i++) begin
      send(1);
      if (ser_out_valid) pulses++;
    end
    chk("def_no_extra", pulses, 1024);
    chk("def_ser_out_zero", ser_out, 0);
    chk("def_count_end", det_count, 1);

    // Overlap in HUNT: pat 101 len 3 win 2
    do_reset();
    load(8'b101, 4'd3, 11'd2, 1'b0);
    send(1); send(0); send(1);
    chk("ovl_det", det_pulse, 1);
    chk("ovl_gate", gate_active, 1);
    send(0);
    chk("ovl_fwd4_v", ser_out_valid, 1);
    chk("ovl_fwd4_d", ser_out, 0);
    send(1);
    chk("ovl_fwd5_v", ser_out_valid, 1);
    chk("ovl_fwd5_d", ser_out, 1);
    chk("ovl_gate_off", gate_active, 0);
    send(1);
    chk("ovl_b6_det", det_pulse, 0);
    chk("ovl_b6_v", ser_out_valid, 0);
    send(1);
    chk("ovl_b7_det", det_pulse, 0);
    chk("ovl_count", det_count, 1);

    // Retrigger: pat 11 len 2 win 3 retrig
    do_reset();
    load(8'b11, 4'd2, 11'd3, 1'b1);
    seq = 7'b1111000;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      send(seq[6-i]);
      if (ser_out_valid) pulses++;
      if (i == 1) chk("rt_det1", det_pulse, 1);
      if (i == 2) chk("rt_b3_det", det_pulse, 0);
      if (i == 3) chk("rt_det2", det_pulse, 1);
      if (i == 5) chk("rt_gate_hold", gate_active, 1);
    end
    chk("rt_pulses", pulses, 5);
    chk("rt_gate_off", gate_active, 0);
    chk("rt_count", det_count, 2);

    // Detect-only then invalid configs
    do_reset();
    load(8'b01, 4'd2, 11'd0, 1'b0);
    send(0); send(1);
    chk("do_det", det_pulse, 1);
    chk("do_gate", gate_active, 0);
    send(0);
    chk("do_gate2", gate_active, 0);
    load(8'b01, 4'd0, 11'd4, 1'b0);
    chk("inv0_err", cfg_err, 1);
    send(0); send(1);
    chk("inv0_no_det", det_pulse, 0);
    chk("inv0_count", det_count, 1);
    load(8'b01, 4'd9, 11'd4, 1'b0);
    chk("inv9_err", cfg_err, 1);
    load(8'b01, 4'd2, 11'd0, 1'b0);
    chk("valid_err_clr", cfg_err, 0);
    send(0); send(1);
    chk("valid_det", det_pulse, 1);
    chk("valid_count", det_count, 2);

    // Config collision mid-window
    do_reset();
    load(8'b11, 4'd2, 11'd4, 1'b0);
    send(1); send(1);
    send(1);
    chk("col_fwd", ser_out, 1);
    pat_cfg = 8'b11; pat_len = 4'd2; win_len = 11'd4; retrig_en = 1'b0;
    cfg_load = 1'b1; bit_valid = 1'b1; ser_in = 1'b1;
    @(posedge FPGAclk); #1;
    cfg_load = 1'b0; bit_valid = 1'b0;
    chk("col_valid", ser_out_valid, 0);
    chk("col_gate", gate_active, 0);
    chk("col_ser_out", ser_out, 0);
    send(1);
    chk("col_bit_dropped", det_pulse, 0);
    send(1);
    chk("col_hunt_det", det_pulse, 1);

    // Reset mid-window restores the default pattern
    do_reset();
    load(8'b11, 4'd2, 11'd8, 1'b0);
    send(1); send(1); send(1);
    chk("mr_pre_fwd", ser_out, 1);
    rst = 1'b1; #1;
    chk("mr_ser_out", ser_out, 0);
    chk("mr_valid", ser_out_valid, 0);
    chk("mr_gate", gate_active, 0);
    chk("mr_count", det_count, 0);
    #1 rst = 1'b0;
    send(0); send(1);
    chk("mr_not_last_cfg", det_pulse, 0);
    send(1); send(1); send(1);
    chk("mr_no_early", det_pulse, 0);
    send(0);
    chk("mr_def_det", det_pulse, 1);

    // Saturation via single-bit detect-only pattern
    do_reset();
    load(8'b1, 4'd1, 11'd0, 1'b0);
    bit_valid = 1'b1; ser_in = 1'b1;
    repeat (65534) @(posedge FPGAclk);
    #1;
    chk("sat_fffe", det_count, 16'hFFFE);
    @(posedge FPGAclk); #1;
    chk("sat_ffff", det_count, 16'hFFFF);
    repeat (2) @(posedge FPGAclk);
    #1;
    chk("sat_hold", det_count, 16'hFFFF);
    chk("sat_det", det_pulse, 1);
    bit_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
